// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encodings and default operand width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR.
// Latency: purely combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;
    assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per cycle, LSB first.
// Latency: done pulses WIDTH+1 cycles after start is accepted; one result per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    assign last_bit = (cnt == CNT_LAST);
    assign psum_nxt = {fa_s, {(WIDTH-1){1'b0}}} | (psum >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        psum  <= '0;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    psum  <= psum_nxt;
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    // Result registers load on the edge into DONE so they are valid alongside done.
                    if (last_bit) begin
                        sum  <= psum_nxt;
                        cout <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
